// File: rtl/x_cfg_lut_k_if.sv
// x_cfg_lut_k_if
//   Signal bundle for one reconfigurable K-input LUT cell.
//   master : the user of the LUT (drives address, config shift and output
//            register enable; receives the lookup results).
//   slave  : the LUT cell itself.
//   Signals
//     ADR       K   lookup address, ADR[0] is the LSB
//     CE        1   config shift enable
//     CDI       1   config serial data in (MSB-first)
//     OCE       1   output register enable
//     O         1   combinational TABLE[ADR]
//     OQ        1   registered TABLE[ADR]
//     CDO       1   cascade out, TABLE[D-1]
//     CFG_DONE  1   one-cycle pulse after every D-th shift
interface x_cfg_lut_k_if #(
  parameter int K = 7
);
  logic [K-1:0] ADR;
  logic         CE;
  logic         CDI;
  logic         OCE;
  logic         O;
  logic         OQ;
  logic         CDO;
  logic         CFG_DONE;

  modport master (
    output ADR,
    output CE,
    output CDI,
    output OCE,
    input  O,
    input  OQ,
    input  CDO,
    input  CFG_DONE
  );

  modport slave (
    input  ADR,
    input  CE,
    input  CDI,
    input  OCE,
    output O,
    output OQ,
    output CDO,
    output CFG_DONE
  );
endinterface

// File: rtl/x_cfg_lut_k.sv
// x_cfg_lut_k
//   K-input LUT with a truth table that can be reloaded at runtime through a
//   serial shift chain. The table resets to INIT, shifts in one bit per CE
//   edge (MSB-first, so the first bit loaded ends up at TABLE[D-1]), and
//   exposes its top bit on CDO so several cells can be chained CDO->CDI.
//   Ports
//     CLK   clock, all state changes on the rising edge
//     RST   synchronous reset, active-low (restores INIT, clears counter,
//           output register and done pulse; wins over CE/OCE)
//     lut   slave side of x_cfg_lut_k_if (ADR/CE/CDI/OCE in,
//           O/OQ/CDO/CFG_DONE out)
//   Parameters
//     K     address width, 1..8; table depth D = 2**K
//     INIT  D-bit reset value of the table, bit i answers ADR == i
module x_cfg_lut_k #(
  parameter int                K    = 7,
  parameter logic [(2**K)-1:0] INIT = '0
) (
  input logic          CLK,
  input logic          RST,
  x_cfg_lut_k_if.slave lut
);

  localparam int D = 2 ** K;

  logic [D-1:0] table_reg;
  logic [D-1:0] table_next;
  logic [K-1:0] cnt_reg;
  logic [K-1:0] cnt_next;
  logic         oq_reg;
  logic         oq_next;
  logic         done_reg;
  logic         done_next;
  logic         cnt_last;

  // The D-th shift of a load is the one taken while the counter sits at D-1.
  assign cnt_last = (cnt_reg == K'(D - 1));

  always_comb begin
    table_next = table_reg;
    cnt_next   = cnt_reg;
    oq_next    = oq_reg;
    done_next  = 1'b0;

    if (lut.CE) begin
      table_next = {table_reg[D-2:0], lut.CDI};
      cnt_next   = cnt_last ? '0 : cnt_reg + K'(1);
      done_next  = cnt_last;
    end

    // Reads the current (pre-shift) table, so a same-edge CE+OCE captures
    // the value that was visible on O during that cycle.
    if (lut.OCE) begin
      oq_next = table_reg[lut.ADR];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      table_reg <= INIT;
      cnt_reg   <= '0;
      oq_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      table_reg <= table_next;
      cnt_reg   <= cnt_next;
      oq_reg    <= oq_next;
      done_reg  <= done_next;
    end
  end

  // A plain variable index: an unknown address yields X on O in a 4-state
  // simulator, which is the intended gate-level behaviour.
  assign lut.O        = table_reg[lut.ADR];
  assign lut.OQ       = oq_reg;
  assign lut.CDO      = table_reg[D-1];
  assign lut.CFG_DONE = done_reg;

endmodule
